// File: rtl/mnist_axi_frame_loader_if.sv
// AXI4-Lite bus between the MNIST frame loader (master) and the inference slave.
interface mnist_axi_frame_loader_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]      M_AWADDR;
  logic                    M_AWVALID;
  logic                    M_AWREADY;
  logic [DATA_WIDTH-1:0]   M_WDATA;
  logic [DATA_WIDTH/8-1:0] M_WSTRB;
  logic                    M_WVALID;
  logic                    M_WREADY;
  logic [1:0]              M_BRESP;
  logic                    M_BVALID;
  logic                    M_BREADY;
  logic [ADDRESS-1:0]      M_ARADDR;
  logic                    M_ARVALID;
  logic                    M_ARREADY;
  logic [DATA_WIDTH-1:0]   M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RVALID;
  logic                    M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, input M_AWREADY,
    output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
    input  M_BRESP, M_BVALID, output M_BREADY,
    output M_ARADDR, M_ARVALID, input M_ARREADY,
    input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
  );

  modport slave (
    input  M_AWADDR, M_AWVALID, output M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
    output M_BRESP, M_BVALID, input M_BREADY,
    input  M_ARADDR, M_ARVALID, output M_ARREADY,
    output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
  );
endinterface

// File: rtl/mnist_axi_frame_loader.sv
// Streams a grayscale frame in, binarizes and packs it into feature words, writes them to the
// MNIST slave over AXI4-Lite, then reads the result word to obtain the predicted class.
module mnist_axi_frame_loader #(
  parameter int ADDRESS     = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PIXELS  = 784,
  parameter int FEAT_WORDS  = 24,
  parameter int RESULT_WORD = 24,
  parameter int THRESHOLD   = 128
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       start,
  input  logic [7:0] px_data,
  input  logic       px_valid,
  output logic       px_ready,
  output logic       busy,
  output logic [3:0] pred,
  output logic       pred_valid,
  output logic       err,
  mnist_axi_frame_loader_if.master m_axi
);
  localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
  localparam int WIDX_W = $clog2(FEAT_WORDS + 1);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] FEAT_PX = CNT_W'(FEAT_WORDS * DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_PX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [7:0]       THR     = 8'(THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WADDR, S_WRESP, S_RADDR, S_RDATA
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      px_cnt;
  logic [WIDX_W-1:0]     word_idx;
  logic [DATA_WIDTH-1:0] pack;
  logic                  aw_done, w_done;
  logic [3:0]            pred_q;

  logic px_fire, aw_fire, w_fire, b_fire, r_fire;
  logic in_feat, word_end, wr_both, px_bit;
  logic unused_rdata;

  assign px_fire  = px_valid & px_ready;
  assign aw_fire  = m_axi.M_AWVALID & m_axi.M_AWREADY;
  assign w_fire   = m_axi.M_WVALID & m_axi.M_WREADY;
  assign b_fire   = m_axi.M_BREADY & m_axi.M_BVALID;
  assign r_fire   = m_axi.M_RREADY & m_axi.M_RVALID;
  assign in_feat  = px_cnt < FEAT_PX;
  assign word_end = &px_cnt[BIT_W-1:0];
  assign wr_both  = (aw_done | aw_fire) & (w_done | w_fire);
  assign px_bit   = px_data >= THR;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (px_fire) begin
                 if (in_feat) begin
                   if (word_end) state_nxt = S_WADDR;
                 end else if (px_cnt == LAST_PX) begin
                   state_nxt = S_RADDR;
                 end
               end
      S_WADDR: if (wr_both) state_nxt = S_WRESP;
      S_WRESP: if (b_fire) state_nxt = S_LOAD;
      S_RADDR: if (m_axi.M_ARREADY) state_nxt = S_RDATA;
      S_RDATA: if (r_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    px_ready        = 1'b0;
    m_axi.M_AWVALID = 1'b0;
    m_axi.M_WVALID  = 1'b0;
    m_axi.M_BREADY  = 1'b0;
    m_axi.M_ARVALID = 1'b0;
    m_axi.M_RREADY  = 1'b0;
    case (state)
      S_LOAD:  px_ready = 1'b1;
      S_WADDR: begin
        m_axi.M_AWVALID = ~aw_done;
        m_axi.M_WVALID  = ~w_done;
      end
      S_WRESP: m_axi.M_BREADY  = 1'b1;
      S_RADDR: m_axi.M_ARVALID = 1'b1;
      S_RDATA: m_axi.M_RREADY  = 1'b1;
      default: ;
    endcase
  end

  // The prediction is reported during the R handshake itself, so a start in that cycle
  // still sees the FSM outside IDLE and is ignored.
  assign pred_valid     = r_fire;
  assign busy           = (state != S_IDLE) & ~pred_valid;
  assign pred           = pred_valid ? m_axi.M_RDATA[3:0] : pred_q;
  assign m_axi.M_AWADDR = ADDRESS'({word_idx, 2'b00});
  assign m_axi.M_WDATA  = pack;
  assign m_axi.M_WSTRB  = '1;
  assign m_axi.M_ARADDR = ADDRESS'(4 * RESULT_WORD);
  assign unused_rdata   = ^m_axi.M_RDATA[DATA_WIDTH-1:4];

  // NOTE: the pack register is reset with the rest of the datapath so WDATA never carries X.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      px_cnt   <= '0;
      word_idx <= '0;
      pack     <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      pred_q   <= '0;
      err      <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        px_cnt   <= '0;
        word_idx <= '0;
        pack     <= '0;
        err      <= 1'b0;
      end
      // Pixel 0 of a word shifts down to bit 0 once all DATA_WIDTH pixels are in.
      if (px_fire) begin
        px_cnt <= px_cnt + CNT_W'(1);
        if (in_feat) pack <= {px_bit, pack[DATA_WIDTH-1:1]};
      end
      if (state == S_WADDR) begin
        if (wr_both) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
      end
      if (b_fire) begin
        word_idx <= word_idx + WIDX_W'(1);
        if (m_axi.M_BRESP != 2'b00) err <= 1'b1;
      end
      if (r_fire) begin
        pred_q <= m_axi.M_RDATA[3:0];
        if (m_axi.M_RRESP != 2'b00) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mnist_axi_frame_loader.sv
// Directed bench for mnist_axi_frame_loader with a stall-configurable AXI4-Lite slave model.
module tb_mnist_axi_frame_loader;
  logic       ACLK;
  logic       ARESETN;
  logic       start;
  logic [7:0] px_data;
  logic       px_valid;
  logic       px_ready;
  logic       busy;
  logic [3:0] pred;
  logic       pred_valid;
  logic       err;

  mnist_axi_frame_loader_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  mnist_axi_frame_loader dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .busy(busy), .pred(pred), .pred_valid(pred_valid), .err(err),
    .m_axi(bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Slave configuration, written by the stimulus process only.
  int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, bad_word = -1;
  logic [3:0] rd_result = 4'd0;

  // Slave state, written by the slave process only.
  logic        p_awv, p_wv, p_arv, p_bready, p_rready;
  logic [31:0] p_awaddr, p_wdata, p_araddr, aw_q, w_q, rd_addr;
  bit          have_aw, have_w, pend_r;
  int          aw_w, w_w, ar_w, r_w;
  int          nw = 0, nb = 0, nr = 0, stab_err = 0;
  logic [31:0] wlog_addr [256];
  logic [31:0] wlog_data [256];

  task automatic slave_idle();
    bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_ARREADY = 1'b0;
    bus.M_BVALID  = 1'b0; bus.M_BRESP  = 2'b00;
    bus.M_RVALID  = 1'b0; bus.M_RRESP  = 2'b00; bus.M_RDATA = '0;
    have_aw = 0; have_w = 0; pend_r = 0;
    aw_w = 0; w_w = 0; ar_w = 0; r_w = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0;
  endtask

  // Readies change only at negedge and valids only at posedge, so the values seen at the
  // previous negedge are exactly those present at the posedge in between.
  task automatic slave_step();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    aw_hs = p_awv && bus.M_AWREADY;
    w_hs  = p_wv  && bus.M_WREADY;
    b_hs  = bus.M_BVALID && p_bready;
    ar_hs = p_arv && bus.M_ARREADY;
    r_hs  = bus.M_RVALID && p_rready;
    if (p_awv && !bus.M_AWREADY && (!bus.M_AWVALID || bus.M_AWADDR != p_awaddr)) stab_err++;
    if (p_wv  && !bus.M_WREADY  && (!bus.M_WVALID  || bus.M_WDATA  != p_wdata))  stab_err++;
    if (p_arv && !bus.M_ARREADY && (!bus.M_ARVALID || bus.M_ARADDR != p_araddr)) stab_err++;
    if (aw_hs) begin aw_q = p_awaddr; have_aw = 1; end
    if (w_hs)  begin w_q  = p_wdata;  have_w  = 1; end
    if (b_hs)  begin bus.M_BVALID = 1'b0; bus.M_BRESP = 2'b00; nb++; end
    if (have_aw && have_w && !bus.M_BVALID) begin
      wlog_addr[nw % 256] = aw_q;
      wlog_data[nw % 256] = w_q;
      nw++;
      bus.M_BVALID = 1'b1;
      bus.M_BRESP  = (aw_q == 32'(bad_word * 4)) ? 2'b10 : 2'b00;
      have_aw = 0; have_w = 0;
    end
    if (ar_hs) begin nr++; rd_addr = p_araddr; pend_r = 1; r_w = 0; end
    if (r_hs)  bus.M_RVALID = 1'b0;
    if (pend_r) begin
      if (r_w >= r_delay) begin
        bus.M_RVALID = 1'b1;
        bus.M_RDATA  = 32'hABCDE000 | 32'(rd_result);
        bus.M_RRESP  = 2'b00;
        pend_r = 0;
      end else r_w++;
    end
    if (aw_hs) begin bus.M_AWREADY = 1'b0; aw_w = 0; end
    else if (bus.M_AWVALID && !bus.M_AWREADY) begin
      if (aw_w >= aw_delay) bus.M_AWREADY = 1'b1; else aw_w++;
    end
    if (w_hs) begin bus.M_WREADY = 1'b0; w_w = 0; end
    else if (bus.M_WVALID && !bus.M_WREADY) begin
      if (w_w >= w_delay) bus.M_WREADY = 1'b1; else w_w++;
    end
    if (ar_hs) begin bus.M_ARREADY = 1'b0; ar_w = 0; end
    else if (bus.M_ARVALID && !bus.M_ARREADY) begin
      if (ar_w >= ar_delay) bus.M_ARREADY = 1'b1; else ar_w++;
    end
    p_awv = bus.M_AWVALID; p_awaddr = bus.M_AWADDR;
    p_wv  = bus.M_WVALID;  p_wdata  = bus.M_WDATA;
    p_arv = bus.M_ARVALID; p_araddr = bus.M_ARADDR;
    p_bready = bus.M_BREADY; p_rready = bus.M_RREADY;
  endtask

  initial begin
    slave_idle();
    forever begin
      @(negedge ACLK);
      if (!ARESETN) slave_idle();
      else          slave_step();
    end
  end

  function automatic logic [7:0] pix(input int mode, input int i);
    if (i >= 784) return 8'h00;
    case (mode)
      0:       return 8'h00;
      1:       return (i < 32 || i == 768) ? 8'hFF : 8'h7F;
      default: return 8'((i * 37 + 11) % 256);
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int mode, input int k);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 32; b++) w[b] = (pix(mode, 32 * k + b) >= 8'd128);
    return w;
  endfunction

  task automatic run_frame(input int mode, input bit rnd, input logic [3:0] result,
                           input bit exp_err, input bit start_mid, input bit start_at_pred);
    int n_acc, nw0, nb0, nr0, se0, cyc;
    bit got;
    nw0 = nw; nb0 = nb; nr0 = nr; se0 = stab_err;
    rd_result = result;
    @(negedge ACLK); #1; start = 1'b1;
    @(negedge ACLK); #1; start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("err_after_start", err, 1'b0);
    n_acc = 0; got = 0; cyc = 0;
    while (!got && cyc < 6000) begin
      if (pred_valid) begin
        got = 1;
        px_valid = 1'b0;
        start    = 1'b0;
        check("pred", pred, result);
        check("busy_at_pred", busy, 1'b0);
        check("px_ready_at_pred", px_ready, 1'b0);
        check("err_at_pred", err, exp_err);
      end else begin
        px_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        px_data  = pix(mode, n_acc);
        if (px_valid && px_ready) n_acc++;
        start = start_mid && n_acc >= 100 && n_acc < 110;
        @(negedge ACLK); #1;
        cyc++;
      end
    end
    check("pred_valid_seen", got, 1'b1);
    if (start_at_pred) begin
      start = 1'b1;
      @(negedge ACLK); #1;
      start = 1'b0;
      check("start_at_pred_busy", busy, 1'b0);
      check("start_at_pred_px_ready", px_ready, 1'b0);
      check("pred_held", pred, result);
      check("pred_valid_pulse", pred_valid, 1'b0);
    end
    check("pixels_consumed", n_acc, 784);
    check("write_count", nw - nw0, 24);
    check("b_count", nb - nb0, 24);
    check("read_count", nr - nr0, 1);
    check("read_addr", rd_addr, 32'h60);
    check("payload_stable", stab_err - se0, 0);
    for (int k = 0; k < 24; k++) begin
      check($sformatf("waddr[%0d]", k), wlog_addr[(nw0 + k) % 256], 32'(4 * k));
      check($sformatf("wdata[%0d]", k), wlog_data[(nw0 + k) % 256], exp_word(mode, k));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    ARESETN = 1'b0; start = 1'b0; px_valid = 1'b0; px_data = 8'h00;
    repeat (3) @(negedge ACLK);
    #1;
    check("rst_px_ready", px_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pred", pred, 4'd0);
    check("rst_pred_valid", pred_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_awvalid", bus.M_AWVALID, 1'b0);
    check("rst_wvalid", bus.M_WVALID, 1'b0);
    check("rst_bready", bus.M_BREADY, 1'b0);
    check("rst_arvalid", bus.M_ARVALID, 1'b0);
    check("rst_rready", bus.M_RREADY, 1'b0);
    ARESETN = 1'b1;

    // Abandon a frame while the first word's AW is stalled.
    aw_delay = 6;
    @(negedge ACLK); #1; start = 1'b1;
    @(negedge ACLK); #1; start = 1'b0;
    px_valid = 1'b1; px_data = 8'hFF;
    cyc = 0;
    while (!bus.M_AWVALID && cyc < 200) begin
      @(negedge ACLK); #1;
      cyc++;
    end
    check("reach_waddr", bus.M_AWVALID, 1'b1);
    ARESETN = 1'b0;
    #1;
    check("midrst_awvalid", bus.M_AWVALID, 1'b0);
    check("midrst_wvalid", bus.M_WVALID, 1'b0);
    check("midrst_px_ready", px_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_pred_valid", pred_valid, 1'b0);
    px_valid = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    ARESETN = 1'b1;
    aw_delay = 0;

    // All-black frame, then a back-to-back frame with W lagging AW by 3 cycles.
    run_frame(0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    w_delay = 3;
    run_frame(1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);

    // AW lagging W, random pixel gaps, slow AR and slow inference, starts while busy.
    aw_delay = 3; w_delay = 0; ar_delay = 10; r_delay = 50;
    run_frame(2, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1);

    // Error response on word 5, then a clean frame that must clear err.
    aw_delay = 0; ar_delay = 0; r_delay = 0; bad_word = 5;
    run_frame(2, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    bad_word = -1;
    run_frame(0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
